// File: rtl/uram_sched_pkg.sv
// Shared defaults and types for the URAM read/write scheduler.
package uram_sched_pkg;

    localparam int unsigned DEF_NUM_MUL      = 4;
    localparam int unsigned DEF_INDEX_WIDTH  = 12;
    localparam int unsigned DEF_DATA_WIDTH   = 64;
    localparam int unsigned DEF_RD_LAT       = 2;
    localparam int unsigned DEF_HAZ_DEPTH    = 6;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    // Hazard window entry at the default table address width.
    localparam int unsigned WIN_INDEX_WIDTH = DEF_INDEX_WIDTH;

    typedef struct packed {
        logic                       valid;
        logic [WIN_INDEX_WIDTH-1:0] index;
    } win_entry_t;

endpackage

// File: rtl/wr_hazard_window.sv
// Tracks writes still in flight in the table write pipeline and flags any
// query index that matches one of them.
module wr_hazard_window
    import uram_sched_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned HAZ_DEPTH   = DEF_HAZ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  logic [INDEX_WIDTH-1:0] query_index,
    output logic                   hit
);

    typedef struct packed {
        logic                   valid;
        logic [INDEX_WIDTH-1:0] index;
    } entry_t;

    // The head of the window is the write being pushed this cycle, so only
    // HAZ_DEPTH-1 stages are registered: a write is hazardous for exactly
    // HAZ_DEPTH cycles starting with its accept cycle.
    localparam int unsigned REG_DEPTH = HAZ_DEPTH - 1;

    entry_t [REG_DEPTH-1:0] entries;

    // Shift the window every cycle, loading the current push at the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries <= '0;
        end else begin
            entries[0] <= '{valid: push, index: push_index};
            for (int unsigned i = 1; i < REG_DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    // Full-index compare against the live push and every registered entry.
    always_comb begin
        hit = push && (push_index == query_index);
        for (int unsigned i = 0; i < REG_DEPTH; i++) begin
            if (entries[i].valid && (entries[i].index == query_index)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uram_rw_scheduler.sv
// Front-end scheduler for the banked URAM table: accepts lookups and updates,
// aligns write stage-0/stage-11 inputs, blocks RAW hazards, bounds read
// starvation and tracks read data validity at the table output.
module uram_rw_scheduler
    import uram_sched_pkg::*;
#(
    parameter int unsigned NUM_MUL      = DEF_NUM_MUL,
    parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned RD_LAT       = DEF_RD_LAT,
    parameter int unsigned HAZ_DEPTH    = DEF_HAZ_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [INDEX_WIDTH-1:0]        rd_req_index,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [INDEX_WIDTH-1:0]        wr_req_index,
    input  logic [NUM_MUL-1:0]            wr_req_mask,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] wr_req_data,
    output logic [INDEX_WIDTH-1:0]        rd_index,
    output logic                          write_reg_0_valid,
    output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
    output logic [NUM_MUL-1:0]            arbiter_result,
    output logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor,
    output logic                          rsp_valid,
    output logic [INDEX_WIDTH-1:0]        rsp_index
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                          wr_fire;
    logic                          rd_fire;
    logic                          hit;
    logic                          throttled;
    logic [CNT_W-1:0]              starve_cnt;
    logic [NUM_MUL-1:0]            mask_d1;
    logic [NUM_MUL-1:0]            mask_d2;
    logic [NUM_MUL*DATA_WIDTH-1:0] data_d1;
    logic [NUM_MUL*DATA_WIDTH-1:0] data_d2;
    logic [RD_LAT:0]               rsp_vld_pipe;
    logic [RD_LAT:0][INDEX_WIDTH-1:0] rsp_idx_pipe;

    wr_hazard_window #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .HAZ_DEPTH   (HAZ_DEPTH)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .push        (wr_fire),
        .push_index  (wr_req_index),
        .query_index (rd_req_index),
        .hit         (hit)
    );

    // Handshakes: writes yield to a starved read, reads yield to any hazard.
    always_comb begin
        throttled    = (starve_cnt == STARVE_MAX);
        wr_req_ready = !throttled;
        wr_fire      = wr_req_valid && wr_req_ready;
        rd_req_ready = !hit;
        rd_fire      = rd_req_valid && rd_req_ready;
    end

    // Write issue: stage-0 register plus mask/data delay to stage-11 alignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg_0_valid <= 1'b0;
            write_reg_0_index <= '0;
            mask_d1           <= '0;
            mask_d2           <= '0;
            data_d1           <= '0;
            data_d2           <= '0;
            arbiter_result    <= '0;
            write_reg_11_xor  <= '0;
        end else begin
            write_reg_0_valid <= wr_fire;
            if (wr_fire) begin
                write_reg_0_index <= wr_req_index;
            end
            mask_d1          <= wr_fire ? wr_req_mask : '0;
            data_d1          <= wr_fire ? wr_req_data : '0;
            mask_d2          <= mask_d1;
            data_d2          <= data_d1;
            arbiter_result   <= mask_d2;
            write_reg_11_xor <= data_d2;
        end
    end

    // Read issue and response pipe tracking data validity at the table output.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_index     <= '0;
            rsp_vld_pipe <= '0;
            rsp_idx_pipe <= '0;
        end else begin
            if (rd_fire) begin
                rd_index <= rd_req_index;
            end
            rsp_vld_pipe[0] <= rd_fire;
            rsp_idx_pipe[0] <= rd_req_index;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                rsp_vld_pipe[i] <= rsp_vld_pipe[i-1];
                rsp_idx_pipe[i] <= rsp_idx_pipe[i-1];
            end
        end
    end

    assign rsp_valid = rsp_vld_pipe[RD_LAT];
    assign rsp_index = rsp_idx_pipe[RD_LAT];

    // Starvation counter: counts consecutive blocked-read cycles, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!rd_req_valid || rd_fire) begin
            starve_cnt <= '0;
        end else if (!throttled) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uram_rw_scheduler.sv
// Randomized scoreboard bench for uram_rw_scheduler.
module tb_uram_rw_scheduler;

    localparam int NUM_MUL = 4;
    localparam int IW      = 12;
    localparam int DW      = 64;
    localparam int RD_LAT  = 2;
    localparam int HAZ     = 6;
    localparam int LIMIT   = 8;
    localparam int WD      = NUM_MUL * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [IW-1:0] rd_req_index = '0;
    logic          wr_req_valid = 1'b0;
    logic          wr_req_ready;
    logic [IW-1:0] wr_req_index = '0;
    logic [NUM_MUL-1:0] wr_req_mask = '0;
    logic [WD-1:0] wr_req_data = '0;
    logic [IW-1:0] rd_index;
    logic          write_reg_0_valid;
    logic [IW-1:0] write_reg_0_index;
    logic [NUM_MUL-1:0] arbiter_result;
    logic [WD-1:0] write_reg_11_xor;
    logic          rsp_valid;
    logic [IW-1:0] rsp_index;

    uram_rw_scheduler #(
        .NUM_MUL      (NUM_MUL),
        .INDEX_WIDTH  (IW),
        .DATA_WIDTH   (DW),
        .RD_LAT       (RD_LAT),
        .HAZ_DEPTH    (HAZ),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_index      (rd_req_index),
        .wr_req_valid      (wr_req_valid),
        .wr_req_ready      (wr_req_ready),
        .wr_req_index      (wr_req_index),
        .wr_req_mask       (wr_req_mask),
        .wr_req_data       (wr_req_data),
        .rd_index          (rd_index),
        .write_reg_0_valid (write_reg_0_valid),
        .write_reg_0_index (write_reg_0_index),
        .arbiter_result    (arbiter_result),
        .write_reg_11_xor  (write_reg_11_xor),
        .rsp_valid         (rsp_valid),
        .rsp_index         (rsp_index)
    );

    typedef struct {
        int            due;
        logic [IW-1:0] idx;
    } rd_exp_t;

    typedef struct {
        int                 due;
        logic [IW-1:0]      idx;
        logic [NUM_MUL-1:0] mask;
        logic [WD-1:0]      data;
    } wr_exp_t;

    rd_exp_t rsp_q[$];
    rd_exp_t rdidx_q[$];
    wr_exp_t wr_q[$];
    wr_exp_t st11_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rst_cyc = 0;

    // Reference model state: cycle of the latest accepted write per index,
    // and the number of consecutive cycles the current read has waited.
    int last_wr[int];
    int starve = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WD-1:0] rand_data();
        logic [WD-1:0] d;
        for (int i = 0; i < WD / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // One bench cycle: drive inputs, predict readiness from the rules, record
    // expected outputs, advance the model.
    task automatic step(input logic rv, input logic [IW-1:0] ridx,
                        input logic wv, input logic [IW-1:0] widx,
                        input logic [NUM_MUL-1:0] mask, input logic [WD-1:0] data,
                        output logic rfire);
        logic wr_rdy_exp, wfire, hazard;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rd_req_valid = rv;
        rd_req_index = ridx;
        wr_req_valid = wv;
        wr_req_index = widx;
        wr_req_mask  = mask;
        wr_req_data  = data;
        #1;
        wr_rdy_exp = (starve != LIMIT);
        wfire      = wv && wr_rdy_exp;
        hazard     = (wfire && widx == ridx) ||
                     (last_wr.exists(int'(ridx)) && (cyc - last_wr[int'(ridx)] < HAZ));
        rfire      = rv && !hazard;
        check("wr_req_ready", wr_req_ready, wr_rdy_exp);
        check("rd_req_ready", rd_req_ready, !hazard);
        if (wfire) begin
            last_wr[int'(widx)] = cyc;
            wr_q.push_back('{due: cyc + 1, idx: widx, mask: mask, data: data});
        end
        if (rfire) begin
            rsp_q.push_back('{due: cyc + 1 + RD_LAT, idx: ridx});
            rdidx_q.push_back('{due: cyc + 1, idx: ridx});
        end
        if (!rv || rfire) starve = 0;
        else if (starve < LIMIT) starve++;
    endtask

    // Hold reset for n cycles with random requests active, then drop all
    // model state and outstanding expectations.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset        = 1'b1;
            rst_cyc      = i;
            rd_req_valid = 1'b1;
            rd_req_index = IW'($urandom_range(0, 7));
            wr_req_valid = 1'b1;
            wr_req_index = IW'($urandom_range(8, 15));
            wr_req_mask  = NUM_MUL'($urandom());
            wr_req_data  = rand_data();
        end
        last_wr.delete();
        starve = 0;
        rsp_q.delete();
        rdidx_q.delete();
        wr_q.delete();
        st11_q.delete();
    endtask

    task automatic hold_read(input logic [IW-1:0] ridx, input logic wv, input logic [IW-1:0] widx);
        logic f;
        int   n;
        f = 1'b0;
        n = 0;
        while (!f && n < 40) begin
            step(1'b1, ridx, wv, widx, NUM_MUL'($urandom()), rand_data(), f);
            n++;
        end
        check("read_fire_bound", f, 1'b1);
    endtask

    task automatic random_phase(input int n);
        logic          f;
        logic          pend;
        logic [IW-1:0] ridx;
        pend = 1'b0;
        ridx = '0;
        for (int i = 0; i < n; i++) begin
            logic rv;
            if (pend) begin
                rv = 1'b1;
            end else begin
                rv   = ($urandom_range(0, 9) < 7);
                ridx = IW'($urandom_range(0, 7));
            end
            step(rv, ridx, ($urandom_range(0, 1) == 1), IW'($urandom_range(0, 7)),
                 NUM_MUL'($urandom()), rand_data(), f);
            pend = rv && !f;
        end
    endtask

    // Monitor: compares DUT outputs against the expectation queues.
    logic [IW-1:0] exp_rd_idx = '0;
    initial begin
        rd_exp_t r;
        wr_exp_t w;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rst_cyc >= 1) begin
                    check("rst_rd_index", rd_index, '0);
                    check("rst_wr0_valid", write_reg_0_valid, '0);
                    check("rst_wr0_index", write_reg_0_index, '0);
                    check("rst_arbiter", arbiter_result, '0);
                    check("rst_wr11_data", write_reg_11_xor, '0);
                    check("rst_rsp_valid", rsp_valid, '0);
                    check("rst_rsp_index", rsp_index, '0);
                    exp_rd_idx = '0;
                end
                continue;
            end
            // write stage 0
            if (write_reg_0_valid) begin
                if (wr_q.size() == 0) begin
                    check("wr0_unexpected", 1'b1, 1'b0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr0_index", write_reg_0_index, w.idx);
                    check("wr0_latency", cyc, w.due);
                    w.due = w.due + 2;
                    st11_q.push_back(w);
                end
            end else if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
                w = wr_q.pop_front();
                check("wr0_missing", 1'b0, 1'b1);
                w.due = w.due + 2;
                st11_q.push_back(w);
            end
            // stage-11 alignment
            if (st11_q.size() > 0 && st11_q[0].due == cyc) begin
                w = st11_q.pop_front();
                check("arbiter_result", arbiter_result, w.mask);
                if (w.mask != '0) check("wr11_data", write_reg_11_xor, w.data);
            end else begin
                check("arbiter_idle", arbiter_result, '0);
            end
            // read issue index, held when idle
            if (rdidx_q.size() > 0 && rdidx_q[0].due == cyc) begin
                r = rdidx_q.pop_front();
                exp_rd_idx = r.idx;
            end
            check("rd_index", rd_index, exp_rd_idx);
            // response
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_index", rsp_index, r.idx);
                    check("rsp_latency", cyc, r.due);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                check("rsp_missing", 1'b0, 1'b1);
            end
        end
    end

    initial begin
        logic f;
        do_reset(3);

        // independent read and write in the same cycle
        step(1'b1, 12'h020, 1'b1, 12'h010, 4'b1010, rand_data(), f);
        check("indep_read_fire", f, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, '0, '0, f);

        // RAW hazard, then same-cycle collision
        step(1'b0, '0, 1'b1, 12'h055, 4'b1111, rand_data(), f);
        hold_read(12'h055, 1'b0, '0);
        step(1'b1, 12'h0AA, 1'b1, 12'h0AA, 4'b0110, rand_data(), f);
        check("collision_blocked", f, 1'b0);
        hold_read(12'h0AA, 1'b0, '0);

        // starvation: writes to the read's index every cycle
        hold_read(12'h001, 1'b1, 12'h001);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 12'h001, 4'b0001, rand_data(), f);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, '0, '0, f);

        // back-to-back reads, no writes
        for (int i = 0; i < 16; i++) begin
            step(1'b1, IW'(12'h100 + i), 1'b0, '0, '0, '0, f);
            check("b2b_read_fire", f, 1'b1);
        end

        random_phase(300);
        do_reset(3);
        random_phase(150);

        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, '0, '0, '0, f);
        check("rsp_drained", rsp_q.size(), 0);
        check("wr_drained", wr_q.size() + st11_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
